// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (one-cycle registered read
// latency, write-over-read priority) into a valid/ready stream through a
// 2-entry skid buffer. Counts completed stream handshakes.
module fifo_stream_reader #(
  parameter int Width    = 8,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic                fifo_wr_busy,
  input  logic [Width-1:0]    fifo_data,
  output logic                fifo_r_en,
  input  logic                flush,
  output logic [Width-1:0]    m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [CntWidth-1:0] xfer_cnt
);

  // buf0 is always the head; buf1 only holds data when occ == 2
  logic [Width-1:0] buf0;
  logic [Width-1:0] buf1;
  logic [1:0]       occ;
  logic             pend;
  logic             pop;
  logic             push;
  logic [2:0]       load_next;

  // Handshake is suppressed during flush so nothing discarded is counted
  assign pop       = (occ != 2'd0) && m_ready && !flush;
  assign push      = pend && !flush;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = buf0;

  // Words owned after this cycle (buffered + in flight - leaving); a new
  // read is only safe while this stays below the buffer depth
  assign load_next = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};

  // The FIFO would silently drop a read issued alongside an accepted write
  assign fifo_r_en = rst_n && !flush && !fifo_empty && !fifo_wr_busy
                     && (load_next < 3'd2);

  // Skid buffer and read-pending tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0 <= '0;
      buf1 <= '0;
      occ  <= 2'd0;
      pend <= 1'b0;
    end else if (flush) begin
      occ  <= 2'd0;
      pend <= 1'b0;
    end else begin
      pend <= fifo_r_en;
      case ({push, pop})
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= fifo_data;
          end else begin
            buf0 <= fifo_data;
          end
        end
        2'b10: begin
          if (occ == 2'd0) buf0 <= fifo_data;
          else             buf1 <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Handshake counter; survives flush, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + 1'b1;
  end

endmodule
